// File: rtl/qs_pio_pkg.sv
// Shared constants for the second-generation PIO slave: register word addresses,
// edge-select codes and interrupt-source codes.
package qs_pio_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET      = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/qs_pio_sync_edge.sv
// Input synchroniser, one-cycle history and edge detector for the PIO pins.
// Edges are suppressed until the chain has filled after reset (priming).
module qs_pio_sync_edge
    import qs_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0]                  prev_reg;
    logic [2:0]                        prime_cnt_reg;
    logic                              primed_reg;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;
    logic [WIDTH-1:0]                  edge_sel;

    // Stage 0 samples the pin; the oldest stage is the synchronised value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
            prev_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Pins held high through reset ripple through as a 0->1 step; primed stays
    // low until that step has been absorbed by prev_reg.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt_reg <= '0;
            primed_reg    <= 1'b0;
        end else if (!primed_reg) begin
            if (prime_cnt_reg == 3'(SYNC_STAGES)) begin
                primed_reg <= 1'b1;
            end else begin
                prime_cnt_reg <= prime_cnt_reg + 3'd1;
            end
        end
    end

    assign in_sync = sync_reg[SYNC_STAGES-1];

    always_comb begin
        rise = in_sync & ~prev_reg;
        fall = ~in_sync & prev_reg;
        case (EDGE_TYPE)
            EDGE_FALL: edge_sel = fall;
            EDGE_ANY:  edge_sel = rise | fall;
            default:   edge_sel = rise;
        endcase
    end

    assign edge_det = primed_reg ? edge_sel : '0;

endmodule

// File: rtl/qs_pio_edge_irq.sv
// Avalon-MM PIO slave: bidirectional GPIO with atomic set/clear, sticky edge
// capture (write-1-to-clear) and a maskable, registered interrupt.
module qs_pio_edge_irq
    import qs_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_TYPE    = IRQ_EDGE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] data_out_reg;
    logic [WIDTH-1:0] data_out_next;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] cap_next;
    logic             irq_reg;
    logic             irq_next;
    logic [WIDTH-1:0] data_rd;
    logic [WIDTH-1:0] rd_val;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    qs_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    always_comb begin
        data_out_next = data_out_reg;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_out_next = wdata;
                ADDR_OUTSET:   data_out_next = data_out_reg | wdata;
                ADDR_OUTCLEAR: data_out_next = data_out_reg & ~wdata;
                default:       data_out_next = data_out_reg;
            endcase
        end
    end

    // Clear is applied before the new edges are OR-ed in, so a coincident edge wins.
    always_comb begin
        cap_next = cap_reg;
        if (wr && address == ADDR_EDGECAPTURE) begin
            cap_next = cap_reg & ~wdata;
        end
        cap_next = cap_next | edge_det;
    end

    generate
        if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
            assign irq_next = |(cap_reg & mask_reg);
        end else begin : g_irq_level
            assign irq_next = |(in_sync & mask_reg);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= RESET_VALUE;
            dir_reg      <= '0;
            mask_reg     <= '0;
            cap_reg      <= '0;
            irq_reg      <= 1'b0;
        end else begin
            data_out_reg <= data_out_next;
            cap_reg      <= cap_next;
            irq_reg      <= irq_next;
            if (wr && address == ADDR_DIRECTION) begin
                dir_reg <= wdata;
            end
            if (wr && address == ADDR_IRQMASK) begin
                mask_reg <= wdata;
            end
        end
    end

    // Output bits read back their driven value, input bits read the pin.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_data_rd
            assign data_rd[gi] = dir_reg[gi] ? data_out_reg[gi] : in_sync[gi];
        end
    endgenerate

    always_comb begin
        case (address)
            ADDR_DATA:        rd_val = data_rd;
            ADDR_DIRECTION:   rd_val = dir_reg;
            ADDR_IRQMASK:     rd_val = mask_reg;
            ADDR_EDGECAPTURE: rd_val = cap_reg;
            default:          rd_val = '0;
        endcase
        readdata            = '0;
        readdata[WIDTH-1:0] = rd_val;
    end

    assign out_port = data_out_reg;
    assign oe       = dir_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_qs_pio_edge_irq.sv
// Bench for qs_pio_edge_irq: an edge-IRQ/rising instance and a level-IRQ/any-edge
// instance share one bus and pin set, both compared every cycle with a reference model.
module tb_qs_pio_edge_irq;
    import qs_pio_pkg::*;

    localparam int         S  = 2;
    localparam logic [7:0] RV = 8'hA5;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [2:0]  address    = 3'd0;
    logic [31:0] writedata  = 32'h0;
    logic [7:0]  in_port    = 8'hFF;

    logic [31:0] rd_e, rd_l;
    logic [7:0]  out_e, out_l, oe_e, oe_l;
    logic        irq_e, irq_l;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: pin history queue, register file, capture sets per edge flavour.
    logic [7:0] m_q[$];
    int         m_edges;
    logic [7:0] m_prev, m_out, m_dir, m_mask, m_cap_r, m_cap_a;
    logic       m_irq_e, m_irq_l;

    always #5 clk = ~clk;

    qs_pio_edge_irq #(
        .WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(EDGE_RISE), .IRQ_TYPE(IRQ_EDGE), .SYNC_STAGES(S)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_e),
        .in_port(in_port), .out_port(out_e), .oe(oe_e), .irq(irq_e)
    );

    qs_pio_edge_irq #(
        .WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(EDGE_ANY), .IRQ_TYPE(IRQ_LEVEL), .SYNC_STAGES(S)
    ) u_lvl (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_l),
        .in_port(in_port), .out_port(out_l), .oe(oe_l), .irq(irq_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        repeat (S) m_q.push_back(8'h00);
        m_edges = 0;
        m_prev  = 8'h00;
        m_out   = RV;
        m_dir   = 8'h00;
        m_mask  = 8'h00;
        m_cap_r = 8'h00;
        m_cap_a = 8'h00;
        m_irq_e = 1'b0;
        m_irq_l = 1'b0;
    endtask

    // Advances the model across one rising clock edge using the inputs now applied.
    task automatic model_step();
        logic [7:0] cur, rise, anyv, clr, wd;
        logic       wr, armed;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_edges++;
            cur   = m_q[0];
            armed = (m_edges >= S + 2);
            rise  = cur & ~m_prev;
            anyv  = cur ^ m_prev;
            wr    = chipselect && !write_n;
            wd    = writedata[7:0];
            clr   = (wr && address == 3'd3) ? wd : 8'h00;
            m_irq_e = |(m_cap_r & m_mask);
            m_irq_l = |(cur & m_mask);
            m_cap_r = (m_cap_r & ~clr) | (armed ? rise : 8'h00);
            m_cap_a = (m_cap_a & ~clr) | (armed ? anyv : 8'h00);
            if (wr) begin
                case (address)
                    3'd0: m_out  = wd;
                    3'd1: m_dir  = wd;
                    3'd2: m_mask = wd;
                    3'd4: m_out  = m_out | wd;
                    3'd5: m_out  = m_out & ~wd;
                    default: ;
                endcase
            end
            m_prev = cur;
            void'(m_q.pop_front());
            m_q.push_back(in_port);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a, input logic [7:0] cap);
        logic [7:0] v;
        case (a)
            3'd0:    v = (m_dir & m_out) | (~m_dir & m_q[0]);
            3'd1:    v = m_dir;
            3'd2:    v = m_mask;
            3'd3:    v = cap;
            default: v = 8'h00;
        endcase
        return {24'h0, v};
    endfunction

    task automatic check_all();
        check("out_e", 32'(out_e), 32'(m_out));
        check("out_l", 32'(out_l), 32'(m_out));
        check("oe_e", 32'(oe_e), 32'(m_dir));
        check("oe_l", 32'(oe_l), 32'(m_dir));
        check("irq_e", 32'(irq_e), 32'(m_irq_e));
        check("irq_l", 32'(irq_l), 32'(m_irq_l));
        check("rd_e", rd_e, m_read(address, m_cap_r));
        check("rd_l", rd_l, m_read(address, m_cap_a));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        $display("[TB] write addr=%0d data=%08h", a, d);
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic set_read(input logic [2:0] a);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = a;
    endtask

    initial begin
        model_reset();
        repeat (3) cycle();
        check("rst_out", 32'(out_e), 32'h0000_00A5);
        check("rst_oe", 32'(oe_e), 32'h0);
        check("rst_irq", 32'(irq_e), 32'h0);
        reset_n = 1'b1;

        // Pins high through reset: no capture while priming.
        set_read(3'd3);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("prime_cap_e", rd_e, 32'h0);
            check("prime_cap_l", rd_l, 32'h0);
        end

        bus_write(3'd0, 32'h0000_003C);
        check("wr_data", 32'(out_e), 32'h3C);
        bus_write(3'd4, 32'hFFFF_FF81);
        check("outset", 32'(out_e), 32'hBD);
        bus_write(3'd5, 32'h0000_000C);
        check("outclear", 32'(out_e), 32'hB1);
        bus_write(3'd1, 32'h0000_00FF);
        set_read(3'd0);
        cycle();
        check("rd_data_out", rd_e, 32'hB1);

        bus_write(3'd1, 32'h0000_000F);
        bus_write(3'd0, 32'h0000_0005);
        in_port = 8'hA0;
        set_read(3'd0);
        repeat (3) cycle();
        check("rd_data_mix", rd_e, 32'hA5);

        // Rising edge on bit 1 with mask 02: capture at k+2, irq at k+3.
        in_port = 8'h00;
        repeat (3) cycle();
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h02);
        set_read(3'd3);
        in_port = 8'h02;
        cycle();
        cycle();
        check("cap_k1", rd_e, 32'h0);
        cycle();
        check("cap_k2", rd_e, 32'h02);
        check("irq_k2", 32'(irq_e), 32'h0);
        cycle();
        check("irq_k3", 32'(irq_e), 32'h1);
        bus_write(3'd3, 32'h02);
        check("irq_clr0", 32'(irq_e), 32'h1);
        cycle();
        check("irq_clr1", 32'(irq_e), 32'h0);

        // Edge and W1C on the same bit at the same edge: set wins.
        in_port = 8'h00;
        repeat (3) cycle();
        bus_write(3'd3, 32'hFF);
        in_port = 8'h02;
        cycle();
        cycle();
        bus_write(3'd3, 32'h02);
        check("set_wins", rd_e, 32'h02);
        bus_write(3'd3, 32'h02);
        in_port = 8'h0A;
        set_read(3'd3);
        repeat (4) cycle();
        check("masked_cap", rd_e, 32'h08);
        check("masked_irq", 32'(irq_e), 32'h0);

        // Level interrupt follows in_sync & mask.
        bus_write(3'd2, 32'h01);
        in_port = 8'h0B;
        repeat (4) cycle();
        check("lvl_hi", 32'(irq_l), 32'h1);
        in_port = 8'h0A;
        repeat (4) cycle();
        check("lvl_lo", 32'(irq_l), 32'h0);
        in_port = 8'h0B;
        repeat (3) cycle();
        check("lvl_hi2", 32'(irq_l), 32'h1);

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_out", 32'(out_e), 32'hA5);
        check("arst_oe", 32'(oe_l), 32'h0);
        check("arst_irq_e", 32'(irq_e), 32'h0);
        check("arst_irq_l", 32'(irq_l), 32'h0);
        @(negedge clk);
        check_all();
        cycle();
        reset_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            address   = 3'($urandom_range(0, 7));
            writedata = $urandom;
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            if (chipselect && !write_n)
                $display("[TB] write addr=%0d data=%08h", address, writedata);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
